// File: rtl/arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr
// Description : N-way round-robin arbiter with a registered one-hot grant and
//               grant hold (burst) semantics. A requester keeps the grant for
//               as long as it keeps requesting. When it releases, the next
//               requester in circular order from the priority pointer wins,
//               with no idle cycle in between.
//               Optional macro ARB_HOLD_LIMIT_EN: when defined, a holder is
//               preempted after MAX_HOLD consecutive cycles if any other
//               channel is requesting.
// Parameters  : N        - number of requesters (2..32)
//               MAX_HOLD - tenure limit in cycles (>= 1, macro build only)
//               IDW      - derived width of grant_id ($clog2(N))
// Ports       : clk         - rising-edge clock
//               reset       - synchronous, active-high reset
//               request     - per-channel level request [N-1:0]
//               grant       - registered one-hot grant, or all-zero [N-1:0]
//               grant_id    - binary index of granted channel, 0 when idle
//               grant_valid - OR of grant
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr #(
    parameter  int N        = 2,
    parameter  int MAX_HOLD = 4,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   request,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid
);

    // The tenure counter only has to hold values 0..MAX_HOLD.
    localparam int c_TEN_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [c_TEN_W-1:0] c_TEN_MAX = c_TEN_W'(MAX_HOLD);
    localparam logic [c_TEN_W-1:0] c_TEN_ONE = c_TEN_W'(1);
    localparam logic [IDW-1:0]     c_LAST_ID = IDW'(N - 1);
    localparam logic [IDW:0]       c_N_EXT   = (IDW + 1)'(N);

    generate
        if (N < 2 || N > 32) begin : g_bad_n
            $error("arbiter_rr: N must be in the range 2..32");
        end
        if (MAX_HOLD < 1) begin : g_bad_hold
            $error("arbiter_rr: MAX_HOLD must be at least 1");
        end
    endgenerate

    logic [N-1:0]       r_grant;
    logic [IDW-1:0]     r_grant_id;
    logic [IDW-1:0]     r_ptr;
    logic [c_TEN_W-1:0] r_tenure;

    logic               w_busy;
    logic               w_limit;
    logic               w_hold;
    logic               w_found;
    logic [IDW-1:0]     w_win_id;
    logic [IDW:0]       w_idx;
    logic [IDW-1:0]     w_next_ptr;

    assign w_busy = |r_grant;

`ifdef ARB_HOLD_LIMIT_EN
    // Preempt only when someone else is waiting; a lone requester at the
    // limit simply keeps the grant with the counter saturated.
    logic w_others;
    assign w_others = |(request & ~r_grant);
    assign w_limit  = (r_tenure == c_TEN_MAX) && w_others;
`else
    assign w_limit  = 1'b0;
`endif

    assign w_hold = w_busy && request[r_grant_id] && !w_limit;

    // Circular search starting at r_ptr. The index is one bit wider than
    // IDW so ptr+k cannot overflow before the modulo-N fold.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW + 1)'(k);
            if (w_idx >= c_N_EXT) begin
                w_idx = w_idx - c_N_EXT;
            end
            if (!w_found && request[w_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_win_id = w_idx[IDW-1:0];
            end
        end
    end

    // Pointer moves just past the winner, so the winner has lowest priority
    // at the next arbitration; explicit wrap keeps non-power-of-two N legal.
    assign w_next_ptr = (w_win_id == c_LAST_ID) ? '0 : (w_win_id + IDW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_tenure   <= '0;
        end else if (w_hold) begin
            if (r_tenure != c_TEN_MAX) begin
                r_tenure <= r_tenure + c_TEN_ONE;
            end
        end else if (w_found) begin
            r_grant    <= {{(N-1){1'b0}}, 1'b1} << w_win_id;
            r_grant_id <= w_win_id;
            r_ptr      <= w_next_ptr;
            r_tenure   <= c_TEN_ONE;
        end else begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_tenure   <= '0;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_rr
// Description : Self-checking bench for arbiter_rr (N=4, MAX_HOLD=4).
//               A driver applies directed then random request/reset patterns
//               on the falling edge and pushes the reference model's expected
//               outputs into a queue; a monitor pops and compares after every
//               rising edge. Honours ARB_HOLD_LIMIT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_rr;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;

    always #5 clk = ~clk;

    arbiter_rr #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // expected = {grant_valid, grant_id[1:0], grant[3:0]}
    logic [6:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Reference model state: holder index (-1 = none), pointer, tenure.
    int m_g   = -1;
    int m_ptr = 0;
    int m_ten = 0;

    task automatic model_step(input logic rst, input logic [3:0] req);
        int  w;
        bit  limit;
        limit = 1'b0;
        if (rst) begin
            m_g   = -1;
            m_ptr = 0;
            m_ten = 0;
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            begin
                bit others;
                others = 1'b0;
                for (int j = 0; j < N; j++) begin
                    if (req[j] && j != m_g) others = 1'b1;
                end
                limit = (m_ten == MAX_HOLD) && others;
            end
`endif
            if (m_g >= 0 && req[m_g] && !limit) begin
                if (m_ten < MAX_HOLD) m_ten = m_ten + 1;
            end else begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (w < 0 && req[j]) w = j;
                end
                if (w >= 0) begin
                    m_g   = w;
                    m_ten = 1;
                    m_ptr = (w + 1) % N;
                end else begin
                    m_g   = -1;
                    m_ten = 0;
                end
            end
        end
    endtask

    function automatic logic [6:0] model_out();
        logic [3:0] g;
        logic [1:0] id;
        if (m_g < 0) return 7'd0;
        g  = 4'd1 << m_g;
        id = 2'(m_g);
        return {1'b1, id, g};
    endfunction

    task automatic drive(input logic rst, input logic [3:0] req, input int n);
        repeat (n) begin
            reset   = rst;
            request = req;
            model_step(rst, req);
            exp_q.push_back(model_out());
            @(negedge clk);
        end
    endtask

    // Monitor: one comparison per cycle for which an expectation exists.
    initial begin
        logic [6:0] exp_v;
        logic [6:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {grant_valid, grant_id, grant};
                tests++;
                if (act_v !== exp_v) begin
                    fails++;
                    $display("FAIL cycle %0d grant/id/valid: got %b/%0d/%b required %b/%0d/%b",
                             cycle, act_v[3:0], act_v[5:4], act_v[6],
                             exp_v[3:0], exp_v[5:4], exp_v[6]);
                end
            end
        end
    end

    // Watchdog: the run must end on its own.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] cur;
        reset   = 1'b1;
        request = 4'b0000;

        // Reset with random requests, then release with a single requester.
        for (int i = 0; i < 10; i++) drive(1'b1, 4'($urandom_range(0, 15)), 1);
        drive(1'b0, 4'b0001, 3);

        // All requesting: rotation with the limit, permanent hold without it.
        drive(1'b0, 4'b1111, 20);

        // Release and handoff from channel 1.
        drive(1'b1, 4'b0000, 1);
        drive(1'b0, 4'b0010, 2);
        drive(1'b0, 4'b1001, 2);
        drive(1'b0, 4'b0001, 2);

        // Wrap: grant at channel 3 leaves the pointer at 0.
        drive(1'b1, 4'b0000, 1);
        drive(1'b0, 4'b1000, 2);
        drive(1'b0, 4'b0011, 2);
        drive(1'b0, 4'b0010, 2);

        // Mid-tenure reset while channel 2 holds.
        drive(1'b1, 4'b0000, 1);
        drive(1'b0, 4'b0100, 1);
        drive(1'b0, 4'b1111, 2);
        drive(1'b1, 4'b1111, 1);
        drive(1'b0, 4'b1111, 3);

        // Random traffic with sticky request patterns and rare resets.
        cur = 4'b0000;
        repeat (2000) begin
            if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 49) == 0), cur, 1);
        end

        @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
